// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: default geometry, field widths,
// FSM state encodings and the queued-store entry layout.
package store_buffer_pkg;

   localparam int unsigned SB_DEPTH  = 4;
   localparam int unsigned SB_PTR_W  = 2;
   localparam int unsigned SB_ADDR_W = 32;
   localparam int unsigned SB_DATA_W = 32;
   localparam int unsigned SB_MASK_W = 4;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LD_REQ  = 3'd1;
   localparam logic [2:0] S_LD_WAIT = 3'd2;
   localparam logic [2:0] S_ST_REQ  = 3'd3;
   localparam logic [2:0] S_ST_WAIT = 3'd4;

   typedef struct packed {
      logic [SB_ADDR_W-1:0] addr;
      logic [SB_DATA_W-1:0] data;
      logic [SB_MASK_W-1:0] mask;
   } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Core-side memory bus between the MEM stage and the store buffer.
//   addr, write_data, memwrite, memread, sign_mask : core -> buffer
//   read_data, core_stall                          : buffer -> core
// master = core side, slave = store buffer side.
interface store_buffer_if;
   import store_buffer_pkg::*;

   logic [SB_ADDR_W-1:0] addr;
   logic [SB_DATA_W-1:0] write_data;
   logic                 memwrite;
   logic                 memread;
   logic [SB_MASK_W-1:0] sign_mask;
   logic [SB_DATA_W-1:0] read_data;
   logic                 core_stall;

   modport master (
      output addr, write_data, memwrite, memread, sign_mask,
      input  read_data, core_stall
   );

   modport slave (
      input  addr, write_data, memwrite, memread, sign_mask,
      output read_data, core_stall
   );

endinterface

// File: rtl/store_buffer_fifo.sv
// sb_fifo: DEPTH-entry store queue.
//   clk, rst_n   : clock, synchronous active-low reset (pointers/count only)
//   push, pop    : enqueue push_entry at tail / retire head entry
//   push_entry   : {addr, data, mask} of the store being absorbed
//   lookup_word  : word address (addr[31:2]) of the current core access
//   head         : oldest queued entry
//   full, empty  : derived from the registered count
//   hit          : some valid entry targets lookup_word
module sb_fifo
   import store_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = SB_DEPTH,
   parameter int unsigned PTR_W = SB_PTR_W
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push,
   input  logic            pop,
   input  sb_entry_t       push_entry,
   input  logic [29:0]     lookup_word,
   output sb_entry_t       head,
   output logic            full,
   output logic            empty,
   output logic            hit
);

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   sb_entry_t        entries [DEPTH];

   // Storage is not reset: validity comes only from rd_ptr/count.
   always_ff @(posedge clk) begin
      if (push) entries[wr_ptr] <= push_entry;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   assign full  = (count == (PTR_W+1)'(DEPTH));
   assign empty = (count == '0);
   assign head  = entries[rd_ptr];

   // Slot i is live when its distance from the head is below count.
   always_comb begin
      logic [PTR_W-1:0] off;
      hit = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         off = PTR_W'(i) - rd_ptr;
         if (({1'b0, off} < count) && (entries[i].addr[31:2] == lookup_word))
            hit = 1'b1;
      end
   end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write buffer between the MEM stage and data_mem.
// Stores are absorbed into sb_fifo without stalling, then drained when
// data_mem is idle. Loads overtake queued stores unless they hit a queued
// word, in which case the queue drains first.
//   clk, rst_n       : clock, synchronous active-low reset
//   core             : core-side bus (store_buffer_if.slave)
//   mem_addr, mem_write_data, mem_memwrite, mem_memread, mem_sign_mask
//                    : requests to data_mem, non-zero only in request states
//   mem_read_data    : load data from data_mem
//   mem_clk_stall    : data_mem busy
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = SB_DEPTH,
   parameter int unsigned PTR_W = SB_PTR_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   store_buffer_if.slave        core,
   output logic [SB_ADDR_W-1:0] mem_addr,
   output logic [SB_DATA_W-1:0] mem_write_data,
   output logic                 mem_memwrite,
   output logic                 mem_memread,
   output logic [SB_MASK_W-1:0] mem_sign_mask,
   input  logic [SB_DATA_W-1:0] mem_read_data,
   input  logic                 mem_clk_stall
);

   logic [2:0]           state;
   logic                 seen_busy;
   logic                 ld_done;
   logic [SB_DATA_W-1:0] read_data_q;
   logic                 push;
   logic                 pop;
   logic                 full;
   logic                 empty;
   logic                 hit;
   logic                 op_done;
   sb_entry_t            head;
   sb_entry_t            push_entry;

   always_comb begin
      push_entry      = '0;
      push_entry.addr = core.addr;
      push_entry.data = core.write_data;
      push_entry.mask = core.sign_mask;
   end

   assign push    = core.memwrite & ~full;
   // data_mem finishes an op by raising then dropping clk_stall.
   assign op_done = seen_busy & ~mem_clk_stall;
   assign pop     = (state == S_ST_WAIT) & op_done;

   sb_fifo #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push        (push),
      .pop         (pop),
      .push_entry  (push_entry),
      .lookup_word (core.addr[31:2]),
      .head        (head),
      .full        (full),
      .empty       (empty),
      .hit         (hit)
   );

   assign core.core_stall = (core.memwrite & full) | (core.memread & ~ld_done);
   assign core.read_data  = read_data_q;

   always_comb begin
      mem_addr       = '0;
      mem_write_data = '0;
      mem_memwrite   = 1'b0;
      mem_memread    = 1'b0;
      mem_sign_mask  = '0;
      case (state)
         S_LD_REQ: begin
            mem_addr      = core.addr;
            mem_sign_mask = core.sign_mask;
            mem_memread   = 1'b1;
         end
         S_ST_REQ: begin
            mem_addr       = head.addr;
            mem_write_data = head.data;
            mem_sign_mask  = head.mask;
            mem_memwrite   = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         seen_busy   <= 1'b0;
         ld_done     <= 1'b0;
         read_data_q <= '0;
      end else begin
         // ld_done is a single-cycle completion pulse.
         ld_done <= 1'b0;
         case (state)
            S_IDLE: begin
               seen_busy <= 1'b0;
               // A hitting load falls through to draining until the hit clears.
               if (core.memread && !ld_done && !hit) state <= S_LD_REQ;
               else if (!empty)                      state <= S_ST_REQ;
            end
            S_LD_REQ: begin
               seen_busy <= 1'b0;
               state     <= S_LD_WAIT;
            end
            S_ST_REQ: begin
               seen_busy <= 1'b0;
               state     <= S_ST_WAIT;
            end
            S_LD_WAIT: begin
               if (mem_clk_stall) begin
                  seen_busy <= 1'b1;
               end else if (seen_busy) begin
                  read_data_q <= mem_read_data;
                  ld_done     <= 1'b1;
                  state       <= S_IDLE;
               end
            end
            S_ST_WAIT: begin
               if (mem_clk_stall) seen_busy <= 1'b1;
               else if (seen_busy) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
   import store_buffer_pkg::*;

   localparam int DEPTH = 4;
   localparam logic [3:0] M_SB  = 4'b0000;
   localparam logic [3:0] M_LB  = 4'b0000;
   localparam logic [3:0] M_SW  = 4'b0010;
   localparam logic [3:0] M_LW  = 4'b0010;
   localparam logic [3:0] M_LBU = 4'b0100;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   store_buffer_if bus();
   logic [31:0] mem_addr, mem_write_data, mem_read_data;
   logic        mem_memwrite, mem_memread, mem_clk_stall;
   logic [3:0]  mem_sign_mask;

   store_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .core           (bus),
      .mem_addr       (mem_addr),
      .mem_write_data (mem_write_data),
      .mem_memwrite   (mem_memwrite),
      .mem_memread    (mem_memread),
      .mem_sign_mask  (mem_sign_mask),
      .mem_read_data  (mem_read_data),
      .mem_clk_stall  (mem_clk_stall)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Byte-lane semantics: mask[1:0] size (0 byte, 1 half, 2 word), mask[2] unsigned.
   function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] lane,
                                         input logic [31:0] wd, input logic [3:0] m);
      logic [31:0] r;
      r = old;
      case (m[1:0])
         2'd0:    r[8*lane +: 8] = wd[7:0];
         2'd1:    r[16*lane[1] +: 16] = wd[15:0];
         default: r = wd;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] lane,
                                            input logic [3:0] m);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[8*lane +: 8];
      h = w[16*lane[1] +: 16];
      case (m[1:0])
         2'd0:    return m[2] ? {24'b0, b} : {{24{b[7]}}, b};
         2'd1:    return m[2] ? {16'b0, h} : {{16{h[15]}}, h};
         default: return w;
      endcase
   endfunction

   // data_mem model: one busy cycle per request, memory updated on request.
   logic [31:0] dmem [int];
   logic        dm_busy = 1'b0;
   logic [31:0] dm_rdata = '0;
   assign mem_clk_stall = dm_busy;
   assign mem_read_data = dm_rdata;

   function automatic logic [31:0] dword(input logic [31:0] a);
      return dmem.exists(int'(a[31:2])) ? dmem[int'(a[31:2])] : 32'h0;
   endfunction

   always @(posedge clk) begin
      if (dm_busy) dm_busy <= 1'b0;
      else if (mem_memwrite) begin
         dmem[int'(mem_addr[31:2])] = merge(dword(mem_addr), mem_addr[1:0], mem_write_data, mem_sign_mask);
         dm_busy <= 1'b1;
      end else if (mem_memread) begin
         dm_rdata <= load_ext(dword(mem_addr), mem_addr[1:0], mem_sign_mask);
         dm_busy  <= 1'b1;
      end
   end

   // Architectural model: committed memory plus program-ordered pending stores.
   typedef struct { logic [31:0] a; logic [31:0] d; logic [3:0] m; } st_t;
   st_t         pend[$];
   logic [31:0] gmem [int];
   int          occ = 0;
   bit [1:0]    pipe = '0;
   bit          prev_wr = 1'b0;
   int          cyc = 0;
   int          n_wr = 0;
   int          last_wr_cyc = 0, last_rd_cyc = 0;
   logic [31:0] last_wr_addr = '0, last_rd_addr = '0;

   function automatic logic [31:0] gword(input logic [31:0] a);
      return gmem.exists(int'(a[31:2])) ? gmem[int'(a[31:2])] : 32'h0;
   endfunction

   function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [3:0] m);
      logic [31:0] w;
      w = gword(a);
      foreach (pend[i])
         if (pend[i].a[31:2] == a[31:2]) w = merge(w, pend[i].a[1:0], pend[i].d, pend[i].m);
      return load_ext(w, a[1:0], m);
   endfunction

   function automatic bit pend_hit(input logic [31:0] a);
      foreach (pend[i]) if (pend[i].a[31:2] == a[31:2]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic commit_head();
      st_t e;
      e = pend.pop_front();
      gmem[int'(e.a[31:2])] = merge(gword(e.a), e.a[1:0], e.d, e.m);
   endtask

   // Compare process: samples just before each rising edge.
   initial begin
      forever begin
         @(negedge clk);
         #3;
         cyc++;
         if (!rst_n) begin
            if (mem_memwrite && pend.size() != 0) commit_head();
            pend.delete();
            occ = 0;
            pipe = '0;
            prev_wr = 1'b0;
         end else begin
            if (bus.memwrite)
               chk("store_stall", 32'(bus.core_stall), 32'(occ == DEPTH));
            else if (!bus.memread)
               chk("idle_stall", 32'(bus.core_stall), 32'd0);
            if (mem_memwrite) begin
               n_wr++;
               last_wr_cyc = cyc;
               last_wr_addr = mem_addr;
               chk("wr_while_busy", 32'(dm_busy), 32'd0);
               chk("wr_pulse_width", 32'(prev_wr), 32'd0);
               chk("wr_and_rd", 32'(mem_memread), 32'd0);
               if (pend.size() == 0) chk("unexpected_wr", 32'd1, 32'd0);
               else begin
                  chk("wr_addr", mem_addr, pend[0].a);
                  chk("wr_data", mem_write_data, pend[0].d);
                  chk("wr_mask", 32'(mem_sign_mask), 32'(pend[0].m));
                  commit_head();
               end
            end
            if (mem_memread) begin
               last_rd_cyc = cyc;
               last_rd_addr = mem_addr;
               chk("rd_while_busy", 32'(dm_busy), 32'd0);
               chk("rd_addr", mem_addr, bus.addr);
               chk("rd_mask", 32'(mem_sign_mask), 32'(bus.sign_mask));
               chk("rd_overtakes_hit", 32'(pend_hit(mem_addr)), 32'd0);
            end
            if (!mem_memwrite && !mem_memread)
               chk("mem_bus_idle", mem_addr | mem_write_data | 32'(mem_sign_mask), 32'd0);
            prev_wr = mem_memwrite;
            if (pipe[1]) occ--;
            pipe = {pipe[0], mem_memwrite};
            if (bus.memwrite && !bus.core_stall) begin
               pend.push_back('{a: bus.addr, d: bus.write_data, m: bus.sign_mask});
               occ++;
            end
         end
      end
   end

   // Core driver: presents one access and holds it until accepted.
   task automatic do_op(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, output int stalls, output logic [31:0] got,
                        output logic [31:0] expv);
      @(negedge clk);
      bus.addr = a; bus.write_data = d; bus.sign_mask = m;
      bus.memwrite = wr; bus.memread = rd;
      stalls = 0; got = '0; expv = '0;
      forever begin
         #1;
         if (!bus.core_stall) begin
            got = bus.read_data;
            if (rd) expv = exp_load(a, m);
            break;
         end
         stalls++;
         if (stalls > 200) begin
            chk("op_timeout", 32'(stalls), 32'd0);
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.memwrite = 1'b0; bus.memread = 1'b0;
         bus.addr = '0; bus.write_data = '0; bus.sign_mask = '0;
      end
   endtask

   task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, output int s);
      logic [31:0] g, e;
      do_op(1'b1, 1'b0, a, d, m, s, g, e);
   endtask

   task automatic ld(input string name, input logic [31:0] a, input logic [3:0] m,
                     output int s, output logic [31:0] g);
      logic [31:0] e;
      do_op(1'b0, 1'b1, a, 32'h0, m, s, g, e);
      chk(name, g, e);
   endtask

   initial begin
      int s;
      int rd_c, wr_snap;
      logic [31:0] g;
      bus.addr = '0; bus.write_data = '0; bus.sign_mask = '0;
      bus.memwrite = 1'b0; bus.memread = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      chk("rst_stall", 32'(bus.core_stall), 32'd0);
      chk("rst_read_data", bus.read_data, 32'd0);
      chk("rst_mem_ctl", 32'({mem_memwrite, mem_memread}), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single store.
      st(32'h1004, 32'hDEADBEEF, M_SW, s);
      chk("sw_no_stall", 32'(s), 32'd0);
      idle(8);
      chk("sw_mem", dword(32'h1004), 32'hDEADBEEF);

      // Five back-to-back stores into a four-entry queue.
      for (int i = 0; i < 5; i++) begin
         st(32'h1100 + 32'(4*i), 32'hA0 + 32'(i), M_SW, s);
         if (i < 4) chk("fill_no_stall", 32'(s), 32'd0);
         else       chk("fifth_stalls", 32'(s > 0), 32'd1);
      end
      idle(30);
      for (int i = 0; i < 5; i++)
         chk("fill_mem", dword(32'h1100 + 32'(4*i)), 32'hA0 + 32'(i));

      // RAW hit forces drain.
      st(32'h1008, 32'h11223344, M_SW, s);
      ld("raw_hit_model", 32'h1008, M_LW, s, g);
      chk("raw_hit_lit", g, 32'h11223344);
      idle(10);

      // Load without hit overtakes a queued store.
      st(32'h1010, 32'h55667788, M_SW, s);
      ld("bypass_model", 32'h1020, M_LW, s, g);
      chk("bypass_lit", g, 32'h0);
      rd_c = last_rd_cyc;
      idle(10);
      chk("bypass_wr_addr", last_wr_addr, 32'h1010);
      chk("bypass_order", 32'(last_wr_cyc > rd_c), 32'd1);
      chk("bypass_mem", dword(32'h1010), 32'h55667788);

      // Sub-word store, sub-word load from another byte of the same word.
      st(32'h100A, 32'h000000AB, M_SB, s);
      ld("sb_lbu_model", 32'h1009, M_LBU, s, g);
      chk("sb_lbu_lit", g, 32'h00000033);
      idle(10);
      chk("sb_mem", dword(32'h1008), 32'h11AB3344);

      // Load latency with empty buffer and idle data_mem.
      ld("lat_model", 32'h1004, M_LW, s, g);
      chk("lat_stalls", 32'(s), 32'd4);
      chk("lat_lit", g, 32'hDEADBEEF);
      idle(5);

      // Reset with stores queued.
      for (int i = 0; i < 3; i++) st(32'h1200 + 32'(4*i), 32'hC0 + 32'(i), M_SW, s);
      @(negedge clk);
      bus.memwrite = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_mid_stall", 32'(bus.core_stall), 32'd0);
      chk("rst_mid_ctl", 32'({mem_memwrite, mem_memread}), 32'd0);
      wr_snap = n_wr;
      idle(10);
      chk("rst_mid_no_wr", 32'(n_wr - wr_snap), 32'd0);
      chk("rst_mid_dropped", dword(32'h1204), 32'h0);

      // Randomized traffic over a small set of words.
      for (int k = 0; k < 400; k++) begin
         int          op;
         logic [31:0] a;
         op = int'($urandom_range(0, 6));
         a  = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
         case (op)
            0, 1: st(a, $urandom, M_SW, s);
            2:    st(a + 32'($urandom_range(0, 3)), $urandom, M_SB, s);
            3:    ld("rand_lw", a, M_LW, s, g);
            4:    ld("rand_lbu", a + 32'($urandom_range(0, 3)), M_LBU, s, g);
            5:    ld("rand_lb", a + 32'($urandom_range(0, 3)), M_LB, s, g);
            default: idle(int'($urandom_range(1, 4)));
         endcase
      end
      idle(40);
      chk("final_drained", 32'(pend.size()), 32'd0);
      chk("final_occ", 32'(occ), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
